// File: rtl/result_pkg.sv
// rtl/result_pkg.sv - shared state encoding, slot sizing and header layout for the result writer
package result_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HDR   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int SLOT_BYTES_DEFAULT = 1550;

    // Header word layout: truncation flag on top, received word count at the bottom
    localparam int HDR_TRUNC_BIT = 31;
    localparam int HDR_CNT_MSB   = 15;
    localparam int HDR_CNT_LSB   = 0;

    function automatic logic [31:0] make_header(input logic trunc, input logic [15:0] count);
        logic [31:0] hdr;
        hdr                          = '0;
        hdr[HDR_TRUNC_BIT]           = trunc;
        hdr[HDR_CNT_MSB:HDR_CNT_LSB] = count;
        return hdr;
    endfunction

endpackage

// File: rtl/result_wr_reg.sv
// rtl/result_wr_reg.sv - single-entry write output register that holds while the memory stalls
module result_wr_reg (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_load,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        i_waitrequest,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic        o_write,
    output logic        o_free
);

    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_write;
    logic        w_free;

    // The entry can take a new write when empty or when its current write completes this cycle
    assign w_free  = !r_write || !i_waitrequest;
    assign o_free  = w_free;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_write = r_write;

    // Load a new write when free; otherwise freeze address, data and request
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_write <= 1'b0;
        end else if (w_free) begin
            r_write <= i_load;
            if (i_load) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/result_writer.sv
// rtl/result_writer.sv - stores matched packets into result slots and commits each slot with a header
module result_writer
    import result_pkg::*;
#(
    parameter int SLOT_BYTES = SLOT_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] base_addr,
    input  logic        base_valid,
    input  logic [31:0] pkt_data,
    input  logic        pkt_valid,
    input  logic        pkt_last,
    input  logic        pkt_match,
    output logic        pkt_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic        mem_waitrequest,
    output logic        inc_addr
);

    localparam int MAX_WORDS = (SLOT_BYTES - 4) / 4;

    state_t      r_state;
    logic        r_base_ok;
    logic [31:0] r_base_q;
    logic        r_trunc;
    logic [15:0] r_rx_words;
    logic        r_hdr_loaded;
    logic        r_inc_addr;

    logic        w_free;
    logic        w_ready;
    logic        w_beat;
    logic        w_store;
    logic        w_load;
    logic [31:0] w_load_addr;
    logic [31:0] w_load_data;
    logic [31:0] w_data_addr;
    logic [15:0] w_rx_next;

    // The current beat's word index is the count of words already received in this slot
    assign w_store     = {16'd0, r_rx_words} < 32'(MAX_WORDS);
    assign w_data_addr = r_base_q + 32'd4 + {14'd0, r_rx_words, 2'b00};
    assign w_rx_next   = (r_rx_words == 16'hFFFF) ? r_rx_words : r_rx_words + 16'd1;
    assign w_beat      = pkt_valid && w_ready;

    // Ready depends on state: waiting for a base in IDLE, on the output register in WRITE
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = r_base_ok;
            ST_WRITE: w_ready = w_free;
            ST_DRAIN: w_ready = 1'b1;
            default:  w_ready = 1'b0;
        endcase
    end

    // Choose what enters the output register: a stored data word or the slot header
    always_comb begin
        w_load      = 1'b0;
        w_load_addr = w_data_addr;
        w_load_data = pkt_data;
        case (r_state)
            ST_IDLE:  w_load = w_beat && pkt_match && w_store;
            ST_WRITE: w_load = w_beat && w_store;
            ST_HDR: begin
                w_load      = !r_hdr_loaded && w_free;
                w_load_addr = r_base_q;
                w_load_data = make_header(r_trunc, r_rx_words);
            end
            default:  w_load = 1'b0;
        endcase
    end

    result_wr_reg u_wr_reg (
        .clk           (clk),
        .n_rst         (n_rst),
        .i_load        (w_load),
        .i_addr        (w_load_addr),
        .i_data        (w_load_data),
        .i_waitrequest (mem_waitrequest),
        .o_addr        (mem_addr),
        .o_data        (mem_wdata),
        .o_write       (mem_write),
        .o_free        (w_free)
    );

    // Slot sequencing: accept a base, stream or drain the packet, write the header, commit
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_base_ok    <= 1'b0;
            r_base_q     <= '0;
            r_trunc      <= 1'b0;
            r_rx_words   <= '0;
            r_hdr_loaded <= 1'b0;
            r_inc_addr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_beat) begin
                        if (pkt_match) begin
                            r_rx_words <= w_rx_next;
                            r_trunc    <= !w_store;
                            r_state    <= pkt_last ? ST_HDR : ST_WRITE;
                        end else begin
                            r_state    <= pkt_last ? ST_IDLE : ST_DRAIN;
                        end
                    end else if (base_valid) begin
                        // A base is only taken while no packet is starting, so word 0 never sees it move
                        r_base_ok <= 1'b1;
                        r_base_q  <= base_addr;
                    end
                end
                ST_WRITE: begin
                    if (w_beat) begin
                        r_rx_words <= w_rx_next;
                        if (!w_store) begin
                            r_trunc <= 1'b1;
                        end
                        if (pkt_last) begin
                            r_state <= ST_HDR;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_beat && pkt_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    // First load the header, then wait until the memory has taken it before committing
                    if (!r_hdr_loaded) begin
                        if (w_free) begin
                            r_hdr_loaded <= 1'b1;
                        end
                    end else if (w_free) begin
                        r_hdr_loaded <= 1'b0;
                        r_inc_addr   <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_inc_addr <= 1'b0;
                    r_base_ok  <= 1'b0;
                    r_trunc    <= 1'b0;
                    r_rx_words <= '0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pkt_ready = w_ready;
    assign inc_addr  = r_inc_addr;

endmodule

// File: tb/tb_result_writer.sv
// tb/tb_result_writer.sv - randomized self-checking bench for result_writer with a slot-level reference model
module tb_result_writer;

    localparam int SLOT_BYTES = 1550;
    localparam int MAX_WORDS  = (SLOT_BYTES - 4) / 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [31:0] base_addr = '0;
    logic        base_valid = 1'b0;
    logic [31:0] pkt_data = '0;
    logic        pkt_valid = 1'b0;
    logic        pkt_last = 1'b0;
    logic        pkt_match = 1'b0;
    logic        pkt_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_waitrequest = 1'b0;
    logic        inc_addr;

    always #5 clk = ~clk;

    result_writer #(.SLOT_BYTES(SLOT_BYTES)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .base_addr       (base_addr),
        .base_valid      (base_valid),
        .pkt_data        (pkt_data),
        .pkt_valid       (pkt_valid),
        .pkt_last        (pkt_last),
        .pkt_match       (pkt_match),
        .pkt_ready       (pkt_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_write       (mem_write),
        .mem_waitrequest (mem_waitrequest),
        .inc_addr        (inc_addr)
    );

    // Reference model: the writes each slot must produce, in order
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic        exp_hdr_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int inc_exp = 0;
    int inc_seen = 0;
    int last_inc_cyc = -100;
    int beat_cyc = 0;
    int data_writes = 0;
    logic [31:0] last_data_addr = '0;
    logic [31:0] last_hdr = '0;

    int   stall_pct = 0;
    logic arm = 1'b0;
    logic [31:0] arm_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory stall generator: random stalls, or one directed 4-cycle stall on an armed address
    int  force_cnt = 0;
    logic fired = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!arm) fired = 1'b0;
        if (force_cnt > 0) begin
            mem_waitrequest = 1'b1;
            force_cnt--;
        end else if (arm && !fired && mem_write && mem_addr == arm_addr) begin
            mem_waitrequest = 1'b1;
            force_cnt = 3;
            fired = 1'b1;
        end else begin
            mem_waitrequest = ($urandom_range(99) < stall_pct);
        end
    end

    // Compare process: every completed write, every stall cycle and every commit pulse
    logic        prev_stall = 1'b0;
    logic        prev_inc = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (n_rst) begin
            if (prev_stall) begin
                check("hold_write", {31'd0, mem_write}, 32'd1);
                check("hold_addr", mem_addr, prev_addr);
                check("hold_data", mem_wdata, prev_data);
            end
            if (mem_write && mem_waitrequest)
                check("ready_during_stall", {31'd0, pkt_ready}, 32'd0);
            if (mem_write && !mem_waitrequest) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write", mem_addr, mem_wdata);
                end else begin
                    check("wr_addr", mem_addr, exp_addr_q.pop_front());
                    check("wr_data", mem_wdata, exp_data_q.pop_front());
                    if (exp_hdr_q.pop_front()) begin
                        last_hdr = mem_wdata;
                    end else begin
                        data_writes++;
                        last_data_addr = mem_addr;
                    end
                end
            end
            if (inc_addr) begin
                check("inc_expected", {31'd0, inc_seen < inc_exp}, 32'd1);
                check("inc_single_cycle", {31'd0, prev_inc}, 32'd0);
                check("inc_after_header", 32'(exp_addr_q.size()), 32'd0);
                inc_seen++;
                last_inc_cyc = cyc;
            end
            prev_stall = mem_write && mem_waitrequest;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
            prev_inc   = inc_addr;
        end else begin
            prev_stall = 1'b0;
            prev_inc   = 1'b0;
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic h);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
        exp_hdr_q.push_back(h);
    endtask

    task automatic give_base(input logic [31:0] a);
        base_addr  = a;
        base_valid = 1'b1;
        @(posedge clk); #1;
        base_valid = 1'b0;
        base_addr  = $urandom;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic match);
        bit ok;
        pkt_valid = 1'b1;
        pkt_data  = d;
        pkt_last  = last;
        pkt_match = match;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            if (pkt_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: got pkt_ready 0 for 500 cycles, required 1");
        end
        beat_cyc = cyc;
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        pkt_data  = $urandom;
        pkt_match = 1'($urandom);
    endtask

    // Model of one packet: matched packets fill words up to the slot limit, then the header
    task automatic send_packet(input int len, input logic match, input logic [31:0] base, input int gap_pct);
        logic [31:0] words[$];
        logic [15:0] cnt;
        for (int i = 0; i < len; i++) words.push_back($urandom);
        if (match) begin
            for (int i = 0; i < len && i < MAX_WORDS; i++)
                push_exp(base + 32'd4 + 32'(4 * i), words[i], 1'b0);
            cnt = (len > 65535) ? 16'hFFFF : 16'(len);
            push_exp(base, {(len > MAX_WORDS), 15'd0, cnt}, 1'b1);
            inc_exp++;
        end
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
                @(posedge clk); #1;
            end
            send_word(words[i], (i == len - 1), (i == 0) ? match : 1'($urandom));
        end
    endtask

    task automatic wait_commit();
        for (int t = 0; t < 300 && inc_seen < inc_exp; t++) @(negedge clk);
        check("commit_seen", 32'(inc_seen), 32'(inc_exp));
        check("writes_drained", 32'(exp_addr_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] cur_base;
        bit need_base;
        int len;
        logic m;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_inc_addr", {31'd0, inc_addr}, 32'd0);
        check("rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        // No base yet: packet must be held off
        pkt_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_base_ready", {31'd0, pkt_ready}, 32'd0);
        end
        @(posedge clk); #1;
        pkt_valid = 1'b0;

        // Three-word slot at 0x060E with hand-computed addresses, header and latency
        give_base(32'h0000_060E);
        push_exp(32'h0000_0612, 32'hA000_000A, 1'b0);
        push_exp(32'h0000_0616, 32'hB000_000B, 1'b0);
        push_exp(32'h0000_061A, 32'hC000_000C, 1'b0);
        push_exp(32'h0000_060E, 32'h0000_0003, 1'b1);
        inc_exp++;
        send_word(32'hA000_000A, 1'b0, 1'b1);
        send_word(32'hB000_000B, 1'b0, 1'b0);
        send_word(32'hC000_000C, 1'b1, 1'b0);
        wait_commit();
        check("inc_latency", 32'(last_inc_cyc - beat_cyc), 32'd3);

        // After a commit, the next packet waits for a fresh base
        pkt_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_commit_ready", {31'd0, pkt_ready}, 32'd0);
        end
        @(posedge clk); #1;
        pkt_valid = 1'b0;

        // Unmatched packet is drained; the base survives for the next matched packet
        give_base(32'h0000_1000);
        @(negedge clk);
        check("base_ok_set", {31'd0, pkt_ready}, 32'd1);
        @(posedge clk); #1;
        send_packet(5, 1'b0, 32'h0000_1000, 0);
        @(negedge clk);
        check("base_ok_kept", {31'd0, pkt_ready}, 32'd1);
        check("drain_no_inc", 32'(inc_seen), 32'(inc_exp));
        @(posedge clk); #1;
        send_packet(3, 1'b1, 32'h0000_1000, 0);
        wait_commit();

        // Four-cycle stall on word 1
        give_base(32'h0000_2000);
        arm_addr = 32'h0000_2008;
        arm = 1'b1;
        send_packet(4, 1'b1, 32'h0000_2000, 0);
        wait_commit();
        arm = 1'b0;

        // Oversized packet truncates at the slot limit
        give_base(32'h0000_0000);
        data_writes = 0;
        send_packet(400, 1'b1, 32'h0000_0000, 0);
        wait_commit();
        check("trunc_data_writes", 32'(data_writes), 32'd386);
        check("trunc_last_addr", last_data_addr, 32'h0000_0608);
        check("trunc_header", last_hdr, 32'h8000_0190);

        // Reset in the middle of a matched packet abandons the slot
        give_base(32'h0000_3000);
        push_exp(32'h0000_3004, 32'h1111_0001, 1'b0);
        push_exp(32'h0000_3008, 32'h1111_0002, 1'b0);
        send_word(32'h1111_0001, 1'b0, 1'b1);
        send_word(32'h1111_0002, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_reset_drained", 32'(exp_addr_q.size()), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b0;
        #2;
        check("midrst_mem_write", {31'd0, mem_write}, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        check("midrst_inc_addr", {31'd0, inc_addr}, 32'd0);
        check("midrst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        pkt_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_base_ok", {31'd0, pkt_ready}, 32'd0);
        end
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        check("post_rst_no_inc", 32'(inc_seen), 32'(inc_exp));
        give_base(32'h0000_4000);
        send_packet(2, 1'b1, 32'h0000_4000, 0);
        wait_commit();

        // Randomized packets with random stalls and gaps
        stall_pct = 25;
        need_base = 1'b1;
        cur_base = '0;
        for (int p = 0; p < 30; p++) begin
            if (need_base) begin
                cur_base = $urandom;
                give_base(cur_base);
                need_base = 1'b0;
            end
            len = ($urandom_range(7) == 0) ? $urandom_range(383, 390) : $urandom_range(1, 9);
            m = 1'($urandom);
            send_packet(len, m, cur_base, 30);
            wait_commit();
            if (m) need_base = 1'b1;
        end
        stall_pct = 0;
        repeat (5) @(posedge clk);
        check("final_drained", 32'(exp_addr_q.size()), 32'd0);
        check("final_commits", 32'(inc_seen), 32'(inc_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 SHALL have parameter SLOT_BYTES, default 1550, giving the bytes per result slot; MAX_WORDS = (SLOT_BYTES-4)/4 (386 at default).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 n_rst  in  1  reset, asynchronous, active-low.
REQ-004 base_addr  in  32  slot base byte address from the result-address stage.
REQ-005 base_valid  in  1  one-cycle pulse; base_addr is valid for a new slot.
REQ-006 pkt_data  in  32  packet word.
REQ-007 pkt_valid  in  1  pkt_data is valid.
REQ-008 pkt_last  in  1  the current word is the final word of the packet.
REQ-009 pkt_match  in  1  packet must be stored; sampled only on the first beat.
REQ-010 pkt_ready  out  1  the block accepts the beat this cycle (beat = pkt_valid & pkt_ready).
REQ-011 mem_addr  out  32  write byte address.
REQ-012 mem_wdata  out  32  write data.
REQ-013 mem_write  out  1  write request.
REQ-014 mem_waitrequest  in  1  the memory stalls the current write.
REQ-015 inc_addr  out  1  one-cycle pulse; the slot is committed and the next base is requested.

Function
REQ-016 SHALL implement the states IDLE, WRITE, DRAIN, HDR and DONE.
REQ-017 base_ok flag: SHALL be set by base_valid in IDLE and latch base_addr into base_q; SHALL ignore base_valid outside IDLE.
REQ-018 IDLE: SHALL drive pkt_ready = base_ok.
REQ-019 IDLE, first beat with pkt_match=1: SHALL go to WRITE and treat the beat as word 0.
REQ-020 IDLE, first beat with pkt_match=0: SHALL go to DRAIN and discard the beat.
REQ-021 A first beat with pkt_last=1 SHALL skip WRITE/DRAIN (matched: HDR; unmatched: IDLE).
REQ-022 Data word n (n < MAX_WORDS) SHALL be written at base_q + 4 + 4n; words n >= MAX_WORDS SHALL be discarded and SHALL set trunc.
REQ-023 The write stage SHALL be a single-entry output register: mem_addr, mem_wdata and mem_write SHALL be held stable while mem_write & mem_waitrequest.
REQ-024 WRITE: SHALL drive pkt_ready = !mem_write | !mem_waitrequest; accepted words reach the bus the cycle after acceptance.
REQ-025 DRAIN: SHALL drive pkt_ready = 1 and issue no writes; on pkt_last SHALL go to IDLE without inc_addr, keeping base_ok.
REQ-026 WRITE, beat with pkt_last: SHALL go to HDR.
REQ-027 HDR: SHALL wait until the output register is free, then write header word {trunc, 15'b0, rx_words[15:0]} at base_q.
REQ-028 rx_words SHALL count every received word and saturate at 16'hFFFF.
REQ-029 HDR: once the header write is accepted, SHALL go to DONE.
REQ-030 DONE: SHALL assert inc_addr for exactly one cycle, clear base_ok, trunc and rx_words, then go to IDLE.
REQ-031 The block SHALL drive pkt_ready=0 in HDR and DONE.
REQ-032 Throughput SHALL be 1 word/cycle with no waitrequest.
REQ-033 Latency from the last data beat to the inc_addr pulse SHALL be 3 cycles when there are no stalls.

Reset
REQ-034 On n_rst=0 the block SHALL enter IDLE and clear base_ok, base_q, trunc and rx_words.
REQ-035 On n_rst=0 the block SHALL drive mem_addr, mem_wdata, mem_write, inc_addr and pkt_ready to 0.
REQ-036 Reset mid-packet SHALL abandon the slot: no header is written and no inc_addr is asserted.

Structure
REQ-037 The state enum, SLOT_BYTES default and the header bit positions (TRUNC=31, count [15:0]) SHALL live in shared package result_pkg.
REQ-038 The output register and its waitrequest hold logic SHALL be sub-module result_wr_reg.

Verification
REQ-039 base_valid with base_addr=0x060E, then a 3-word matched packet A,B,C with no stalls -> writes 0x0612=A, 0x0616=B, 0x061A=C, then 0x060E=0x00000003, and one inc_addr pulse 3 cycles after C.
REQ-040 Unmatched 5-word packet -> no mem_write, no inc_addr, base_ok still set; a following matched packet uses the same base.
REQ-041 Matched 400-word packet at base 0 -> exactly 386 data writes (last at 0x608) and header 0x80000190 at 0x0.
REQ-042 mem_waitrequest held for 4 cycles on word 1 -> address and data stable, pkt_ready low, no words lost or duplicated.
REQ-043 pkt_valid with no base_valid since the previous commit -> pkt_ready stays 0 until base_valid arrives.
REQ-044 n_rst pulsed after 2 words of a matched packet -> no header, no inc_addr, outputs 0, IDLE with base_ok=0.
